// File: rtl/mps_seq_pkg.sv
// mps_seq_pkg: on/off step codes shared by the MPS sequencer and the MPS system FSM.
package mps_seq_pkg;
   typedef enum logic [3:0] {
      ON_IDLE, ON_MC_OFF, ON_MC_OFF_WAIT, ON_MAIN_ON, ON_MAIN_WAIT, ON_PRECHG_ON,
      ON_PRECHG_WAIT, ON_DCLINK_WAIT, ON_DCLINK_STABLE, ON_BYPASS_ON, ON_BYPASS_WAIT,
      ON_PRECHG_OFF, ON_PRECHG_OFF_WAIT, ON_SETTLE, ON_DONE, ON_FAIL
   } on_step_t;
   typedef enum logic [3:0] {OFF_IDLE, OFF_OUT_OFF, OFF_ALL_OFF, OFF_DONE} off_step_t;
   // Contactor feedback {main, precharge, bypass} that releases each wait step
   function automatic logic [2:0] mc_fb_expect(on_step_t s);
      case (s)
         ON_MAIN_WAIT:       return 3'b100;
         ON_PRECHG_WAIT:     return 3'b110;
         ON_BYPASS_WAIT:     return 3'b111;
         ON_PRECHG_OFF_WAIT: return 3'b101;
         default:            return 3'b000;
      endcase
   endfunction
endpackage

// File: rtl/mps_dwell_timer.sv
// mps_dwell_timer: 32-bit step dwell counter, cleared on step entry, saturating at all-ones.
module mps_dwell_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        enable,
   output logic [31:0] count
);
   always_ff @(posedge clk)
      if (!rst_n || clear) count <= '0;
      else if (enable && count != '1) count <= count + 32'd1;
endmodule

// File: rtl/mps_op_sequencer.sv
// mps_op_sequencer: contactor on/off sequencing for the MPS power stage.
// MPS_MC_FB_CHECK_EN enables feedback/DC-link qualification and the FAIL timeout.
module mps_op_sequencer import mps_seq_pkg::*; #(
   parameter logic [31:0] DLY_CYC    = 32'd1000,
   parameter logic [31:0] FB_TMO_CYC = 32'd100000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_op_on_flag,
   input  logic       i_op_off_flag,
   input  logic       i_intl_flag,
   input  logic [2:0] i_mc_fb,
   input  logic       i_dc_link_ok,
   output logic [3:0] o_op_on_fsm,
   output logic [3:0] o_op_off_fsm,
   output logic       o_busy,
   output logic [3:0] o_fail_step
);
   on_step_t    on_st, on_nxt;
   off_step_t   off_st, off_nxt;
   logic [31:0] cnt;
   logic        dwell_done;
   assign dwell_done = cnt >= DLY_CYC - 32'd1;
`ifdef MPS_MC_FB_CHECK_EN
   logic tmo;
   assign tmo = cnt >= FB_TMO_CYC - 32'd1;
`else
   logic unused_in;
   assign unused_in = ^{i_mc_fb, i_dc_link_ok, FB_TMO_CYC};
`endif
   always_comb begin
      on_nxt = on_st;
      off_nxt = off_st;
      case (on_st)
         ON_MC_OFF, ON_MAIN_ON, ON_PRECHG_ON, ON_BYPASS_ON, ON_PRECHG_OFF:
            on_nxt = on_step_t'(on_st + 4'd1);
         ON_MC_OFF_WAIT, ON_MAIN_WAIT, ON_PRECHG_WAIT, ON_BYPASS_WAIT, ON_PRECHG_OFF_WAIT:
`ifdef MPS_MC_FB_CHECK_EN
            on_nxt = (dwell_done && i_mc_fb == mc_fb_expect(on_st)) ? on_step_t'(on_st + 4'd1) :
                     tmo ? ON_FAIL : on_st;
`else
            on_nxt = dwell_done ? on_step_t'(on_st + 4'd1) : on_st;
`endif
         ON_DCLINK_WAIT:
`ifdef MPS_MC_FB_CHECK_EN
            on_nxt = i_dc_link_ok ? ON_DCLINK_STABLE : tmo ? ON_FAIL : on_st;
`else
            on_nxt = dwell_done ? ON_DCLINK_STABLE : on_st;
`endif
         ON_DCLINK_STABLE:
`ifdef MPS_MC_FB_CHECK_EN
            // a DC-link drop re-enters DCLINK_WAIT, which restarts its timeout
            on_nxt = !i_dc_link_ok ? ON_DCLINK_WAIT : dwell_done ? ON_BYPASS_ON :
                     tmo ? ON_FAIL : on_st;
`else
            on_nxt = ON_BYPASS_ON;
`endif
         ON_SETTLE:        on_nxt = dwell_done ? ON_DONE : on_st;
         ON_DONE, ON_FAIL: on_nxt = ON_IDLE;
         default: ;
      endcase
      case (off_st)
         OFF_OUT_OFF: off_nxt = dwell_done ? OFF_ALL_OFF : off_st;
         OFF_ALL_OFF: off_nxt = dwell_done ? OFF_DONE : off_st;
         OFF_DONE:    off_nxt = OFF_IDLE;
         default: ;
      endcase
      if (i_op_off_flag && off_st == OFF_IDLE) begin
         off_nxt = OFF_OUT_OFF;
         on_nxt = ON_IDLE;
      end else if (i_intl_flag) on_nxt = ON_IDLE;
      else if (i_op_on_flag && on_st == ON_IDLE && off_st == OFF_IDLE) on_nxt = ON_MC_OFF;
   end
   always_ff @(posedge i_clk)
      if (!i_rst) begin
         on_st <= ON_IDLE;
         off_st <= OFF_IDLE;
         o_busy <= 1'b0;
         o_fail_step <= '0;
      end else begin
         on_st <= on_nxt;
         off_st <= off_nxt;
         o_busy <= on_nxt != ON_IDLE || off_nxt != OFF_IDLE;
         if (on_nxt == ON_FAIL) o_fail_step <= on_st;
         else if (on_st == ON_IDLE && on_nxt == ON_MC_OFF) o_fail_step <= '0;
      end
   assign o_op_on_fsm = on_st;
   assign o_op_off_fsm = off_st;
   mps_dwell_timer u_timer (
      .clk(i_clk),
      .rst_n(i_rst),
      .clear(on_nxt != on_st || off_nxt != off_st),
      .enable(o_busy),
      .count(cnt)
   );
endmodule
